// File: rtl/sdu_uart_rx.sv
// sdu_uart_rx: 8N1 UART receiver (LSB first), 16x oversampled, one-entry valid/ready holding register.
// Define SDU_RX_PARITY_EN to insert an even-parity bit between the data and stop bits (11-bit frame).
`timescale 1ns/1ps
module sdu_uart_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       dout_vld,
    input  logic       dout_rdy,
    output logic       frm_err,
    output logic       ovf,
    output logic       busy
);

    localparam int OSR_RAW = CLK_FREQ / (BAUD * 16);
    localparam int OSR_DIV = (OSR_RAW < 1) ? 1 : OSR_RAW;
    localparam int DIV_W   = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OSR_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SDU_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state;
    logic             rxd_m;
    logic             rxd_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       s_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
`ifdef SDU_RX_PARITY_EN
    logic             par_bad;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: synchroniser resets to the idle line level so reset release is never mistaken for a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // Oversample divider is parked at 0 while idle, so it restarts cleanly on start detection.
    assign tick = (state != S_IDLE) && (state != S_BREAK) && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (state == S_IDLE || state == S_BREAK || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            s_cnt    <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            frm_err  <= 1'b0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
`ifdef SDU_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
        end else begin
            frm_err <= 1'b0;
            ovf     <= 1'b0;

            // A handshake empties the holding register unless a delivery below refills it.
            if (dout_vld && dout_rdy) begin
                dout_vld <= 1'b0;
            end

            if (tick) begin
                s_cnt <= s_cnt + 4'd1;
            end

            case (state)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state <= S_START;
                        s_cnt <= '0;
                        busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (tick && s_cnt == 4'd7) begin
                        s_cnt <= '0;
                        if (!rxd_s) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                S_DATA: begin
                    if (tick && s_cnt == 4'd15) begin
                        shreg   <= {rxd_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef SDU_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end

`ifdef SDU_RX_PARITY_EN
                S_PARITY: begin
                    if (tick && s_cnt == 4'd15) begin
                        par_bad <= (rxd_s != ^shreg);
                        state   <= S_STOP;
                    end
                end
`endif

                S_STOP: begin
                    if (tick && s_cnt == 4'd15) begin
                        if (rxd_s) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
`ifdef SDU_RX_PARITY_EN
                            if (par_bad) begin
                                frm_err <= 1'b1;
                            end else
`endif
                            if (!dout_vld || dout_rdy) begin
                                dout     <= shreg;
                                dout_vld <= 1'b1;
                            end else begin
                                ovf <= 1'b1;
                            end
                        end else begin
                            // Held-low line: flag once, then wait for idle instead of decoding 0x00s.
                            frm_err <= 1'b1;
                            state   <= S_BREAK;
                        end
                    end
                end

                S_BREAK: begin
                    if (rxd_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdu_uart_rx.sv
// Scoreboard bench for sdu_uart_rx at 64 clk/bit: stimulus pushes expected bytes, a monitor pops on handshake.
`timescale 1ns/1ps
module tb_sdu_uart_rx;

    localparam int CLK_FREQ = 6_400_000;
    localparam int BAUD     = 100_000;
    localparam int BIT_CLK  = 64;
`ifdef SDU_RX_PARITY_EN
    localparam int PAR_CLK  = 64;
`else
    localparam int PAR_CLK  = 0;
`endif
    // rxd fall -> stop-sample edge: 2 sync + 1 detect + 8 ticks*4 + 8 bits*64 + 64 (+ parity bit)
    localparam int STOP_EDGE = 611 + PAR_CLK;
    localparam int LAT_NOM   = 610 + PAR_CLK;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_rdy;
    logic       frm_err;
    logic       ovf;
    logic       busy;

    sdu_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .frm_err  (frm_err),
        .ovf      (ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int t_start = 0;
    int frm_cnt = 0, ovf_cnt = 0, vld_cyc_cnt = 0, xfer_cnt = 0;
    int vld_rise_cyc = 0, busy_fall_cyc = 0;
    logic prev_vld = 1'b0, prev_busy = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every transfer against the scoreboard and tallies pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (dout_vld && dout_rdy) begin
                xfer_cnt++;
                check("sb_has_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("sb_dout", dout, exp_q.pop_front());
            end
            if (frm_err)  frm_cnt++;
            if (ovf)      ovf_cnt++;
            if (dout_vld) vld_cyc_cnt++;
            if (dout_vld && !prev_vld) vld_rise_cyc = cyc;
            if (!busy && prev_busy)    busy_fall_cyc = cyc;
        end
        prev_vld  = dout_vld;
        prev_busy = busy;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_b);
        t_start = cyc;
        rxd = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
`ifdef SDU_RX_PARITY_EN
        rxd = ^b;
        repeat (BIT_CLK) @(negedge clk);
`endif
        rxd = stop_b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

`ifdef SDU_RX_PARITY_EN
    task automatic send_par(input logic [7:0] b, input logic par);
        rxd = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rxd = par;
        repeat (BIT_CLK) @(negedge clk);
        rxd = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
    endtask
`endif

    task automatic set_rdy(input logic v);
        @(posedge clk);
        #2 dout_rdy = v;
        @(negedge clk);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, o0, v0, x0, lat;
        rst = 1'b1;
        rxd = 1'b1;
        dout_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 8'h00);
        check("rst_vld", dout_vld, 0);
        check("rst_frm_err", frm_err, 0);
        check("rst_ovf", ovf, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 1: basic byte, consumer always ready
        f0 = frm_cnt; o0 = ovf_cnt; v0 = vld_cyc_cnt;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        lat = vld_rise_cyc - t_start;
        check("a5_vld_one_cycle", vld_cyc_cnt - v0, 1);
        check("a5_no_frm_err", frm_cnt - f0, 0);
        check("a5_no_ovf", ovf_cnt - o0, 0);
        check("a5_busy_idle", busy, 0);
        check("a5_latency_ok", (lat >= LAT_NOM - 6) && (lat <= LAT_NOM + 6), 1);
        check("a5_busy_fall_ok", (busy_fall_cyc - vld_rise_cyc >= 0) && (busy_fall_cyc - vld_rise_cyc <= 1), 1);
        check("a5_sb_empty", exp_q.size(), 0);

        // 2: 20-clk glitch is rejected silently
        f0 = frm_cnt; v0 = vld_cyc_cnt;
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        check("glitch_busy_during", busy, 1);
        repeat (20) @(negedge clk);
        check("glitch_busy_cleared", busy, 0);
        check("glitch_no_frm_err", frm_cnt - f0, 0);
        check("glitch_no_vld", vld_cyc_cnt - v0, 0);
        repeat (BIT_CLK) @(negedge clk);

        // 3: framing error, held-low break, then recovery
        f0 = frm_cnt; v0 = vld_cyc_cnt;
        send_byte(8'h3C, 1'b0);
        repeat (200) @(negedge clk);
        check("brk_one_frm_err", frm_cnt - f0, 1);
        check("brk_no_vld", vld_cyc_cnt - v0, 0);
        check("brk_busy_held", busy, 1);
        rxd = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        check("brk_released", busy, 0);
        x0 = xfer_cnt;
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        check("brk_55_xfer", xfer_cnt - x0, 1);
        check("brk_55_sb_empty", exp_q.size(), 0);

        // 4: overrun while consumer stalls
        set_rdy(1'b0);
        o0 = ovf_cnt; x0 = xfer_cnt;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        check("ovf_dout_kept", dout, 8'h11);
        check("ovf_vld_held", dout_vld, 1);
        check("ovf_one_pulse", ovf_cnt - o0, 1);
        set_rdy(1'b1);
        repeat (3) @(negedge clk);
        check("ovf_one_xfer", xfer_cnt - x0, 1);
        check("ovf_vld_cleared", dout_vld, 0);
        check("ovf_sb_empty", exp_q.size(), 0);

        // 5: accept and reload in the same cycle
        set_rdy(1'b0);
        o0 = ovf_cnt;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        repeat (4) @(negedge clk);
        exp_q.push_back(8'h77);
        fork
            send_byte(8'h77, 1'b1);
            begin
                repeat (STOP_EDGE - 1) @(posedge clk);
                #2 dout_rdy = 1'b1;
                @(posedge clk);
                #2 dout_rdy = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("same_cyc_no_ovf", ovf_cnt - o0, 0);
        check("same_cyc_dout", dout, 8'h77);
        check("same_cyc_vld", dout_vld, 1);
        check("same_cyc_sb_left", exp_q.size(), 1);
        set_rdy(1'b1);
        repeat (3) @(negedge clk);
        check("same_cyc_sb_empty", exp_q.size(), 0);

        // 6: reset in the middle of data bit 4
        v0 = vld_cyc_cnt;
        fork
            send_byte(8'hF0, 1'b1);
            begin
                repeat (5 * BIT_CLK + 20) @(negedge clk);
                check("rst_mid_busy_before", busy, 1);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                check("rst_mid_dout", dout, 8'h00);
                check("rst_mid_busy", busy, 0);
                rst = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        check("rst_mid_no_vld", vld_cyc_cnt - v0, 0);
        x0 = xfer_cnt;
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1);
        repeat (4) @(negedge clk);
        check("rst_mid_0f_xfer", xfer_cnt - x0, 1);

`ifdef SDU_RX_PARITY_EN
        // 7: parity mismatch (0x07 needs parity 1)
        f0 = frm_cnt; v0 = vld_cyc_cnt;
        send_par(8'h07, 1'b0);
        repeat (4) @(negedge clk);
        check("par_frm_err", frm_cnt - f0, 1);
        check("par_no_vld", vld_cyc_cnt - v0, 0);
        check("par_busy_idle", busy, 0);
`endif

        check("final_sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
